// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the default geometry, the index of the hardwired zero register and
// an address-width helper that never returns less than one bit.
package rf_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int ZERO_IDX     = 0;

  // Address width for n entries; a one-entry file still needs a 1-bit address.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rd_addr  [NUM_RD*AW] read addresses from decode, port k at [k*AW +: AW]
//   rd_busy  [NUM_RD]    port k's register still waits for its writeback
//   wr_en/wr_addr        writeback event, clears the busy bit
//   iss_en/iss_addr      issue event, sets the busy bit (set beats clear)
//   sb_err               sticky: a writeback hit a register that was not busy
//   busy_vec [NUM_REGS]  raw busy bits for debug
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = clog2_safe(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 sb_err,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                err_next;
  logic                wr_is_zero;
  logic                iss_is_zero;

  assign wr_is_zero  = (ZERO_REG != 0) && (wr_addr  == AW'(ZERO_IDX));
  assign iss_is_zero = (ZERO_REG != 0) && (iss_addr == AW'(ZERO_IDX));

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    busy_next = busy;
    // Clear before set: a new producer issued in the writeback cycle of the
    // old one must stay outstanding.
    if (wr_en && !wr_is_zero)   busy_next[wr_addr]  = 1'b0;
    if (iss_en && !iss_is_zero) busy_next[iss_addr] = 1'b1;
    if (ZERO_REG != 0)          busy_next[ZERO_IDX] = 1'b0;
  end

  assign err_next = sb_err | (wr_en & ~wr_is_zero & ~busy[wr_addr]);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= busy_next;
      sb_err <= err_next;
    end
  end

  // Busy as seen by decode this cycle: pre-edge state, except that a
  // forwarded writeback already satisfies the dependency.
  always_comb begin
    logic [AW-1:0] a;
    rd_busy = '0;
    a       = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a          = rd_addr[k*AW +: AW];
      rd_busy[k] = busy[a] & ~((BYPASS != 0) && wr_en && (wr_addr == a));
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised integer register file with write-to-read bypass, optional
// hardwired zero register and a pending-write scoreboard for RAW detection.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rd_addr  [NUM_RD*AW] read addresses, port k at [k*AW +: AW]
//   rd_data  [NUM_RD*XLEN] combinational read data, port k at [k*XLEN +: XLEN]
//   rd_busy  [NUM_RD]    port k's register has an outstanding write
//   wr_en/wr_addr/wr_data writeback port
//   iss_en/iss_addr      issue port, marks the destination pending
//   sb_err               sticky writeback-to-non-busy error
//   busy_vec [NUM_REGS]  raw scoreboard state
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = clog2_safe(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic                   sb_err,
  output logic [NUM_REGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == AW'(ZERO_IDX)));

  // NOTE: the array is reset entry by entry because the architectural state
  // must read zero right after reset; a plain RAM without reset is not enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: array value, overridden by the same-cycle writeback, then
  // forced to zero for the hardwired register and while reset is asserted
  // (a writeback presented during reset must not leak through the bypass).
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] val;
    rd_data = '0;
    a       = '0;
    val     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a   = rd_addr[k*AW +: AW];
      val = regs[a];
      if ((BYPASS != 0) && wr_ok && (wr_addr == a)) val = wr_data;
      if ((ZERO_REG != 0) && (a == AW'(ZERO_IDX)))  val = '0;
      if (!rst_n)                                   val = '0;
      rd_data[k*XLEN +: XLEN] = val;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .sb_err   (sb_err),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vectors on a bypassing and a non-bypassing
// 32x32 two-port instance driven in lockstep, plus a 16x64 four-port instance
// exercised with random traffic against a small reference model.
module tb_reg_file_sb;

  localparam int AW   = 5;
  localparam int XW   = 32;
  localparam int C_AW = 4;
  localparam int C_XW = 64;
  localparam int C_RD = 4;
  localparam int C_N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // shared stimulus for instances a (BYPASS=1) and b (BYPASS=0)
  logic [2*AW-1:0] rd_addr;
  logic            wr_en, iss_en;
  logic [AW-1:0]   wr_addr, iss_addr;
  logic [XW-1:0]   wr_data;
  logic [2*XW-1:0] rd_data_a, rd_data_b;
  logic [1:0]      rd_busy_a, rd_busy_b;
  logic            sb_err_a, sb_err_b;
  logic [31:0]     busy_vec_a, busy_vec_b;

  // instance c (16 regs, 4 ports, 64 bits)
  logic [C_RD*C_AW-1:0] c_rd_addr;
  logic [C_RD*C_XW-1:0] c_rd_data;
  logic [C_RD-1:0]      c_rd_busy;
  logic                 c_wr_en, c_iss_en, c_sb_err;
  logic [C_AW-1:0]      c_wr_addr, c_iss_addr;
  logic [C_XW-1:0]      c_wr_data;
  logic [C_N-1:0]       c_busy_vec;

  reg_file_sb dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .sb_err(sb_err_a), .busy_vec(busy_vec_a)
  );

  reg_file_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .sb_err(sb_err_b), .busy_vec(busy_vec_b)
  );

  reg_file_sb #(.XLEN(64), .NUM_REGS(16), .NUM_RD(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .iss_en(c_iss_en), .iss_addr(c_iss_addr), .sb_err(c_sb_err), .busy_vec(c_busy_vec)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic do_reset_pulse;
    #1 rst_n = 1'b0;
    #1;
  endtask

  // reference model for instance c
  logic [C_XW-1:0] m_regs [C_N];
  logic [C_N-1:0]  m_busy;
  logic            m_err;

  initial begin
    rst_n    = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_addr = '0;
    idle();
    c_rd_addr = '0; c_wr_en = 1'b0; c_iss_en = 1'b0;
    c_wr_addr = '0; c_iss_addr = '0; c_wr_data = '0;

    // ---- reset state ----
    #2;
    check("rst_data_a", rd_data_a, 64'h0);
    check("rst_busy_vec_a", busy_vec_a, 64'h0);
    check("rst_sb_err_a", sb_err_a, 64'h0);
    #10 rst_n = 1'b1;
    tick();

    // ---- asynchronous reset mid-operation ----
    iss_en = 1'b1; iss_addr = 5'd5;
    tick();
    iss_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd5; rd_addr = {5'd0, 5'd5};
    tick();
    idle();
    #1;
    check("pre_rst_x5_a", rd_data_a[31:0], 64'hDEADBEEF);
    check("pre_rst_busy5_a", busy_vec_a[5], 64'h1);
    check("pre_rst_rd_busy_a", rd_busy_a, 64'h1);
    do_reset_pulse();
    check("async_rst_x5_a", rd_data_a[31:0], 64'h0);
    check("async_rst_x5_b", rd_data_b[31:0], 64'h0);
    check("async_rst_busy_vec_a", busy_vec_a, 64'h0);
    check("async_rst_busy_vec_b", busy_vec_b, 64'h0);
    check("async_rst_rd_busy_a", rd_busy_a, 64'h0);
    check("async_rst_sb_err_a", sb_err_a, 64'h0);
    #2 rst_n = 1'b1;
    tick();

    // ---- zero register ----
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    #1;
    check("zero_bypass_a", rd_data_a, 64'h0);
    tick();
    idle();
    #1;
    check("zero_read_a", rd_data_a, 64'h0);
    check("zero_read_b", rd_data_b, 64'h0);
    check("zero_busy0_a", busy_vec_a[0], 64'h0);
    check("zero_rd_busy_a", rd_busy_a, 64'h0);
    check("zero_sb_err_a", sb_err_a, 64'h0);

    // ---- bypass ----
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;   // re-issue keeps x7 busy
    tick();
    iss_en = 1'b0; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd7};
    #1;
    check("byp_p0_a", rd_data_a[31:0], 64'h12345678);
    check("byp_p1_a", rd_data_a[63:32], 64'h12345678);
    check("byp_p0_b", rd_data_b[31:0], 64'h11111111);
    check("byp_p1_b", rd_data_b[63:32], 64'h11111111);
    check("byp_rd_busy_a", rd_busy_a, 64'h0);
    check("byp_rd_busy_b", rd_busy_b, 64'h3);
    tick();
    idle();
    #1;
    check("byp_next_p0_b", rd_data_b[31:0], 64'h12345678);
    check("byp_next_p1_b", rd_data_b[63:32], 64'h12345678);
    check("byp_next_p0_a", rd_data_a[31:0], 64'h12345678);
    check("byp_busy7_a", busy_vec_a[7], 64'h0);
    check("byp_sb_err_a", sb_err_a, 64'h0);

    // ---- scoreboard lifecycle on x3 ----
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd3};
    #1;
    check("life_same_cycle_iss_a", rd_busy_a[0], 64'h0);
    tick();
    idle();
    #1;
    check("life_busy_a", rd_busy_a[0], 64'h1);
    check("life_busy_b", rd_busy_b[0], 64'h1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
    #1;
    check("life_wb_rd_busy_a", rd_busy_a[0], 64'h0);
    check("life_wb_rd_busy_b", rd_busy_b[0], 64'h1);
    check("life_wb_data_a", rd_data_a[31:0], 64'hA5);
    check("life_wb_data_b", rd_data_b[31:0], 64'h0);
    tick();
    idle();
    #1;
    check("life_busy3_a", busy_vec_a[3], 64'h0);
    check("life_busy3_b", busy_vec_b[3], 64'h0);
    check("life_data_a", rd_data_a[31:0], 64'hA5);
    check("life_data_b", rd_data_b[31:0], 64'hA5);

    // ---- simultaneous issue and writeback on busy x9 ----
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rd_addr = {5'd9, 5'd3};
    #1;
    check("sim_rd_busy1_a", rd_busy_a[1], 64'h0);
    check("sim_rd_busy1_b", rd_busy_b[1], 64'h1);
    tick();
    idle();
    #1;
    check("sim_busy9_a", busy_vec_a[9], 64'h1);
    check("sim_busy9_b", busy_vec_b[9], 64'h1);
    check("sim_data9_a", rd_data_a[63:32], 64'h99);
    check("sim_data9_b", rd_data_b[63:32], 64'h99);
    check("sim_rd_busy1_after_a", rd_busy_a[1], 64'h1);
    check("sim_sb_err_a", sb_err_a, 64'h0);

    // ---- spurious writeback to x12 ----
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC;
    #1;
    check("spur_before_edge_a", sb_err_a, 64'h0);
    tick();
    idle();
    #1;
    check("spur_err_a", sb_err_a, 64'h1);
    check("spur_err_b", sb_err_b, 64'h1);
    check("spur_busy12_a", busy_vec_a[12], 64'h0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;   // legal writeback to busy x9
    tick();
    idle();
    #1;
    check("spur_sticky_a", sb_err_a, 64'h1);
    check("spur_busy9_cleared_a", busy_vec_a[9], 64'h0);
    tick();
    check("spur_sticky2_a", sb_err_a, 64'h1);
    do_reset_pulse();
    check("spur_rst_a", sb_err_a, 64'h0);
    check("spur_rst_b", sb_err_b, 64'h0);
    #2 rst_n = 1'b1;
    tick();

    // ---- parameter sweep: 16 regs, 4 ports, 64 bits ----
    for (int i = 0; i < C_N; i++) m_regs[i] = '0;
    m_busy = '0;
    m_err  = 1'b0;
    check("c_rst_busy_vec", c_busy_vec, 64'h0);
    check("c_rst_sb_err", c_sb_err, 64'h0);

    for (int cyc = 0; cyc < 300; cyc++) begin
      logic [C_AW-1:0] wa;
      logic [C_AW-1:0] probe;
      logic            found;
      logic [C_AW-1:0] ra;
      logic [C_XW-1:0] exp_d;
      logic            exp_b;

      wa    = C_AW'($urandom_range(0, C_N - 1));
      found = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        for (int j = 0; j < C_N; j++) begin
          probe = wa + C_AW'(j);
          if (!found && m_busy[probe]) begin
            found = 1'b1;
            wa    = probe;
          end
        end
      end
      c_wr_en    = ($urandom_range(0, 1) == 1);
      c_wr_addr  = wa;
      c_wr_data  = {$urandom, $urandom};
      c_iss_en   = ($urandom_range(0, 2) != 0);
      c_iss_addr = C_AW'($urandom_range(0, C_N - 1));
      for (int k = 0; k < C_RD; k++) begin
        if ($urandom_range(0, 3) == 0) ra = wa;
        else ra = C_AW'($urandom_range(0, C_N - 1));
        c_rd_addr[k*C_AW +: C_AW] = ra;
      end
      #1;
      for (int k = 0; k < C_RD; k++) begin
        ra = c_rd_addr[k*C_AW +: C_AW];
        if (ra == 0) begin
          exp_d = '0;
          exp_b = 1'b0;
        end else if (c_wr_en && c_wr_addr == ra) begin
          exp_d = c_wr_data;
          exp_b = 1'b0;
        end else begin
          exp_d = m_regs[ra];
          exp_b = m_busy[ra];
        end
        check("c_rd_data", c_rd_data[k*C_XW +: C_XW], exp_d);
        check("c_rd_busy", c_rd_busy[k], 64'(exp_b));
      end
      check("c_busy_vec", c_busy_vec, 64'(m_busy));
      check("c_sb_err", c_sb_err, 64'(m_err));

      if (c_wr_en && c_wr_addr != 0) begin
        if (!m_busy[c_wr_addr]) m_err = 1'b1;
        m_regs[c_wr_addr] = c_wr_data;
        m_busy[c_wr_addr] = 1'b0;
      end
      if (c_iss_en && c_iss_addr != 0) m_busy[c_iss_addr] = 1'b1;
      tick();
    end
    c_wr_en  = 1'b0;
    c_iss_en = 1'b0;
    #1;
    check("c_final_busy_vec", c_busy_vec, 64'(m_busy));
    check("c_final_sb_err", c_sb_err, 64'(m_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
